fc_rx_word_sync: RTL and testbench
==================================

// Module: fc_rx_word_sync
// PURPOSE
// - FC-1 receive word-synchronization stage directly downstream of the fc_8g_xcvr PHY RX parallel port (32b + 4 K flags).
// - Classifies each transmission word and runs the FC-FS loss-of-sync state machine.
// - Forwards words to the FC-2 framer with valid/error tagging and exports link status plus statistics counters.
// PARAMETERS
// - ACQUIRE_OS     3   consecutive valid ordered sets required to leave LOSS_OF_SYNC
// - INVALID_LIMIT  4   invalid-word depth that returns SYNC_ACQ to LOSS_OF_SYNC
// - GOOD_RUN       2   consecutive valid words that step the invalid depth down by 1
// - CNT_W          16  width of the saturating statistics counters
// PORTS
// - clk             in   1      PHY rx_clkout domain clock
// - reset_n         in   1      asynchronous, active-low reset
// - rx_ready        in   1      PHY RX ready; 0 forces LOSS_OF_SYNC
// - rx_data         in   32     PHY word; byte0 = bits[7:0], first on wire
// - rx_datak        in   4      per-byte K flag
// - rx_errdetect    in   4      per-byte 8b10b code error
// - rx_disperr      in   4      per-byte disparity error
// - rx_syncstatus   in   4      per-byte PHY comma alignment
// - out_data        out  32     forwarded word
// - out_datak       out  4      forwarded K flags
// - out_valid       out  1      word forwarded while synchronized
// - out_err         out  1      forwarded word was an invalid transmission word
// - out_os          out  1      forwarded word is an ordered set (byte0 = K28.5)
// - word_sync       out  1      1 when state != LOSS_OF_SYNC
// - los_count       out  CNT_W  entries into LOSS_OF_SYNC from a sync state; saturating
// - invalid_count   out  CNT_W  invalid words seen while synchronized; saturating
// - clear_counters  in   1      synchronous clear of both counters; has priority over increment
// BEHAVIOUR
// - Reset: all outputs 0, state LOSS_OF_SYNC, all internal run counters 0.
// - Stage 1 registers inputs and classifies. Valid word = no errdetect, no disperr, all four syncstatus bits set, and either datak==0 or (datak==4'b0001 and byte0==8'hBC).
// - Ordered set = valid word with datak==4'b0001 and byte0==8'hBC. Any other K pattern is invalid.
// - Stage 2 updates the state machine and registers the outputs. Latency is a fixed 2 clk, rx_* to out_*; no backpressure.
// - States: LOSS_OF_SYNC, SYNC_ACQ, SYNC_INV1..SYNC_INV(INVALID_LIMIT-1).
// - LOSS_OF_SYNC: count consecutive valid OS. Any non-OS word zeroes the count. Reaching ACQUIRE_OS moves to SYNC_ACQ. The word that completes acquisition is forwarded.
// - SYNC_ACQ: an invalid word moves to SYNC_INV1.
// - SYNC_INVn: an invalid word moves to SYNC_INV(n+1) and zeroes good_run. At INVALID_LIMIT invalid depth, go to LOSS_OF_SYNC and increment los_count.
// - SYNC_INVn: each valid word increments good_run. When good_run reaches GOOD_RUN, step to SYNC_INV(n-1) (or SYNC_ACQ from INV1) and zero good_run.
// - rx_ready==0 (sampled in stage 1): next state is LOSS_OF_SYNC, acquisition count is zeroed, the word is not counted as invalid. los_count increments only if previously synchronized.
// - out_valid=1 iff the state after the update is != LOSS_OF_SYNC. out_err=1 only for forwarded invalid words; the word that causes loss of sync has out_valid=0.
// - out_data/out_datak always carry the stage-2 word; they are meaningful only when out_valid=1.
// - Counters saturate at all-ones with no wrap. When clear_counters and an increment occur in the same cycle, the result is 0.
// - invalid_count increments for every invalid word sampled in any sync state, including the one causing loss of sync.
// - Reset asserted mid-operation returns everything to reset values asynchronously. Counters are also cleared by reset.
// STRUCTURE
// - fc_pkg: K28_5 = 8'hBC constant; typedef enum for word_sync states; typedef struct for a classified word {data, datak, valid, os}.
// - One sub-module, fc_word_classify: combinational classifier plus stage-1 register.
// - The state machine, counters and output register live in fc_rx_word_sync.
// TESTING
// - After reset, feed 3 valid IDLE OS (BC,95,B5,B5; datak 0001) -> word_sync rises with the 3rd OS at 2-clk latency; out_valid and out_os =1 for that word.
// - Feed 2 OS, 1 data word, then 3 OS -> sync is reached only after the final 3 OS; no out_valid before that.
// - In sync, inject 3 invalid words (errdetect=0001) -> out_err=1 x3, word_sync stays 1, invalid_count=3. A 4th invalid -> word_sync=0, los_count=1, invalid_count=4.
// - In sync, sequence invalid,valid,valid,invalid,invalid,invalid -> state ends at INV3, sync held; a 4th consecutive invalid -> loss of sync.
// - In sync, drop rx_ready for 1 clk -> word_sync=0 two clk later, los_count+1, invalid_count unchanged; 3 OS re-acquire.
// - Force invalid_count to 16'hFFFF, then inject an invalid word -> value stays FFFF. Assert clear_counters on an incrementing cycle -> value is 0.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_pkg                                                                     |
// | Shared constants and types for the FC-1 receive word-synchronization path. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fc_pkg;

  localparam logic [7:0] c_K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    ST_LOSS_OF_SYNC = 2'd0,
    ST_SYNC_ACQ     = 2'd1,
    ST_SYNC_INV     = 2'd2
  } sync_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  datak;
    logic        valid;
    logic        os;
  } fc_word_t;

endpackage
`default_nettype wire

// File: rtl/fc_word_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_word_classify                                                           |
// | Classifies a PHY transmission word and registers it (pipeline stage 1).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fc_word_classify
  import fc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_rx_ready,
  input  logic [31:0] i_rx_data,
  input  logic [3:0]  i_rx_datak,
  input  logic [3:0]  i_rx_errdetect,
  input  logic [3:0]  i_rx_disperr,
  input  logic [3:0]  i_rx_syncstatus,
  output fc_word_t    o_word,
  output logic        o_ready
);

  logic     w_is_k28_5;
  logic     w_clean;
  fc_word_t w_word;
  fc_word_t r_word;
  logic     r_ready;

  // Only an ordered set may carry a K character, and only in byte 0.
  assign w_is_k28_5 = (i_rx_datak == 4'b0001) && (i_rx_data[7:0] == c_K28_5);
  assign w_clean    = (i_rx_errdetect == 4'b0000) && (i_rx_disperr == 4'b0000) &&
                      (i_rx_syncstatus == 4'b1111);

  always_comb begin
    w_word       = '0;
    w_word.data  = i_rx_data;
    w_word.datak = i_rx_datak;
    w_word.valid = w_clean && ((i_rx_datak == 4'b0000) || w_is_k28_5);
    w_word.os    = w_clean && w_is_k28_5;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_word  <= w_word;
      r_ready <= i_rx_ready;
    end
  end

  assign o_word  = r_word;
  assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/fc_rx_word_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_rx_word_sync                                                            |
// | FC-1 receive word sync: loss-of-sync state machine, tagging and counters.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fc_rx_word_sync
  import fc_pkg::*;
#(
  parameter int ACQUIRE_OS    = 3,
  parameter int INVALID_LIMIT = 4,
  parameter int GOOD_RUN      = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_ready,
  input  logic [31:0]      rx_data,
  input  logic [3:0]       rx_datak,
  input  logic [3:0]       rx_errdetect,
  input  logic [3:0]       rx_disperr,
  input  logic [3:0]       rx_syncstatus,
  output logic [31:0]      out_data,
  output logic [3:0]       out_datak,
  output logic             out_valid,
  output logic             out_err,
  output logic             out_os,
  output logic             word_sync,
  output logic [CNT_W-1:0] los_count,
  output logic [CNT_W-1:0] invalid_count,
  input  logic             clear_counters
);

  localparam int c_ACQ_W   = $clog2(ACQUIRE_OS + 1);
  localparam int c_DEPTH_W = $clog2(INVALID_LIMIT + 1);
  localparam int c_GOOD_W  = $clog2(GOOD_RUN + 1);

  fc_word_t             w_s1_word;
  logic                 w_s1_ready;
  sync_state_t          r_state, w_state_nxt;
  logic [c_ACQ_W-1:0]   r_acq_cnt, w_acq_nxt, w_acq_inc;
  logic [c_DEPTH_W-1:0] r_inv_depth, w_depth_nxt, w_depth_inc;
  logic [c_GOOD_W-1:0]  r_good_run, w_good_nxt, w_good_inc;
  logic                 w_los_inc, w_inv_inc, w_fwd;
  logic [31:0]          r_out_data;
  logic [3:0]           r_out_datak;
  logic                 r_out_valid, r_out_err, r_out_os;
  logic [CNT_W-1:0]     r_los_count, r_invalid_count;

  fc_word_classify u_classify (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_rx_ready      (rx_ready),
    .i_rx_data       (rx_data),
    .i_rx_datak      (rx_datak),
    .i_rx_errdetect  (rx_errdetect),
    .i_rx_disperr    (rx_disperr),
    .i_rx_syncstatus (rx_syncstatus),
    .o_word          (w_s1_word),
    .o_ready         (w_s1_ready)
  );

  assign w_acq_inc   = r_acq_cnt + 1'b1;
  assign w_depth_inc = r_inv_depth + 1'b1;
  assign w_good_inc  = r_good_run + 1'b1;

  // SYNC_ACQ is invalid depth 0; SYNC_INV covers depths 1..INVALID_LIMIT-1.
  always_comb begin
    w_state_nxt = r_state;
    w_acq_nxt   = r_acq_cnt;
    w_depth_nxt = r_inv_depth;
    w_good_nxt  = r_good_run;
    w_los_inc   = 1'b0;
    w_inv_inc   = 1'b0;
    if (!w_s1_ready) begin
      w_state_nxt = ST_LOSS_OF_SYNC;
      w_acq_nxt   = '0;
      w_depth_nxt = '0;
      w_good_nxt  = '0;
      w_los_inc   = (r_state != ST_LOSS_OF_SYNC);
    end else begin
      case (r_state)
        ST_LOSS_OF_SYNC: begin
          if (!w_s1_word.os) begin
            w_acq_nxt = '0;
          end else if (w_acq_inc == c_ACQ_W'(ACQUIRE_OS)) begin
            w_state_nxt = ST_SYNC_ACQ;
            w_acq_nxt   = '0;
          end else begin
            w_acq_nxt = w_acq_inc;
          end
        end
        default: begin
          if (!w_s1_word.valid) begin
            w_inv_inc  = 1'b1;
            w_good_nxt = '0;
            if (w_depth_inc == c_DEPTH_W'(INVALID_LIMIT)) begin
              w_state_nxt = ST_LOSS_OF_SYNC;
              w_depth_nxt = '0;
              w_los_inc   = 1'b1;
            end else begin
              w_state_nxt = ST_SYNC_INV;
              w_depth_nxt = w_depth_inc;
            end
          end else if (r_state == ST_SYNC_INV) begin
            if (w_good_inc == c_GOOD_W'(GOOD_RUN)) begin
              w_good_nxt = '0;
              if (r_inv_depth == c_DEPTH_W'(1)) begin
                w_state_nxt = ST_SYNC_ACQ;
                w_depth_nxt = '0;
              end else begin
                w_depth_nxt = r_inv_depth - 1'b1;
              end
            end else begin
              w_good_nxt = w_good_inc;
            end
          end
        end
      endcase
    end
  end

  assign w_fwd = (w_state_nxt != ST_LOSS_OF_SYNC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_LOSS_OF_SYNC;
      r_acq_cnt   <= '0;
      r_inv_depth <= '0;
      r_good_run  <= '0;
      r_out_data  <= '0;
      r_out_datak <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_os    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acq_cnt   <= w_acq_nxt;
      r_inv_depth <= w_depth_nxt;
      r_good_run  <= w_good_nxt;
      r_out_data  <= w_s1_word.data;
      r_out_datak <= w_s1_word.datak;
      r_out_valid <= w_fwd;
      r_out_err   <= w_fwd && !w_s1_word.valid;
      r_out_os    <= w_fwd && w_s1_word.os;
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_los_count     <= '0;
      r_invalid_count <= '0;
    end else if (clear_counters) begin
      r_los_count     <= '0;
      r_invalid_count <= '0;
    end else begin
      if (w_los_inc && (r_los_count != '1)) begin
        r_los_count <= r_los_count + 1'b1;
      end
      if (w_inv_inc && (r_invalid_count != '1)) begin
        r_invalid_count <= r_invalid_count + 1'b1;
      end
    end
  end

  assign out_data      = r_out_data;
  assign out_datak     = r_out_datak;
  assign out_valid     = r_out_valid;
  assign out_err       = r_out_err;
  assign out_os        = r_out_os;
  assign word_sync     = (r_state != ST_LOSS_OF_SYNC);
  assign los_count     = r_los_count;
  assign invalid_count = r_invalid_count;

endmodule
`default_nettype wire

// File: tb/tb_fc_rx_word_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fc_rx_word_sync                                                         |
// | Directed plus random stimulus against a sync/counter reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fc_rx_word_sync;

  localparam int ACQ  = 3;
  localparam int LIM  = 4;
  localparam int GRUN = 2;
  localparam int CMAX = 65535;
  localparam logic [31:0] IDLE = 32'hB5B595BC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic [3:0]  rx_datak = '0;
  logic [3:0]  rx_errdetect = '0;
  logic [3:0]  rx_disperr = '0;
  logic [3:0]  rx_syncstatus = '0;
  logic        clear_counters = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_valid, out_err, out_os, word_sync;
  logic [15:0] los_count, invalid_count;

  always #5 clk = ~clk;

  fc_rx_word_sync dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_datak       (rx_datak),
    .rx_errdetect   (rx_errdetect),
    .rx_disperr     (rx_disperr),
    .rx_syncstatus  (rx_syncstatus),
    .out_data       (out_data),
    .out_datak      (out_datak),
    .out_valid      (out_valid),
    .out_err        (out_err),
    .out_os         (out_os),
    .word_sync      (word_sync),
    .los_count      (los_count),
    .invalid_count  (invalid_count),
    .clear_counters (clear_counters)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  datak;
    logic        vld, err, os, sync;
    int          los, inv;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   m_sync;
  int   m_acq, m_depth, m_good, m_los, m_inv;
  bit   pend_clr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sync = 0; m_acq = 0; m_depth = 0; m_good = 0; m_los = 0; m_inv = 0;
    pend_clr = 0;
  endtask

  // One word per call: check the word issued two calls ago, then drive and model this one.
  task automatic step(input logic rdy, input logic [31:0] d, input logic [3:0] k,
                      input logic [3:0] e, input logic [3:0] dp, input logic [3:0] ss,
                      input bit clr);
    exp_t x;
    bit   v, o;
    @(negedge clk);
    if (q.size() == 2) begin
      x = q.pop_front();
      chk("out_data", out_data, x.data);
      chk("out_datak", {28'd0, out_datak}, {28'd0, x.datak});
      chk("valid_err_os_sync", {28'd0, out_valid, out_err, out_os, word_sync},
          {28'd0, x.vld, x.err, x.os, x.sync});
      chk("los_count", {16'd0, los_count}, x.los);
      chk("invalid_count", {16'd0, invalid_count}, x.inv);
    end
    clear_counters = pend_clr;
    pend_clr       = clr;
    rx_ready       = rdy;
    rx_data        = d;
    rx_datak       = k;
    rx_errdetect   = e;
    rx_disperr     = dp;
    rx_syncstatus  = ss;
    v = (e == 4'h0) && (dp == 4'h0) && (ss == 4'hF) &&
        ((k == 4'h0) || ((k == 4'h1) && (d[7:0] == 8'hBC)));
    o = v && (k == 4'h1);
    if (!rdy) begin
      if (m_sync) m_los++;
      m_sync = 0; m_acq = 0; m_depth = 0; m_good = 0;
    end else if (!m_sync) begin
      if (o) begin
        m_acq++;
        if (m_acq == ACQ) begin m_sync = 1; m_acq = 0; end
      end else m_acq = 0;
    end else if (!v) begin
      m_inv++; m_good = 0; m_depth++;
      if (m_depth == LIM) begin m_sync = 0; m_los++; m_depth = 0; end
    end else if (m_depth > 0) begin
      m_good++;
      if (m_good == GRUN) begin m_depth--; m_good = 0; end
    end
    if (m_los > CMAX) m_los = CMAX;
    if (m_inv > CMAX) m_inv = CMAX;
    if (clr) begin m_los = 0; m_inv = 0; end
    x = '{data: d, datak: k, vld: m_sync, err: m_sync && !v, os: m_sync && o,
          sync: m_sync, los: m_los, inv: m_inv};
    q.push_back(x);
  endtask

  task automatic os_w();   step(1'b1, IDLE, 4'h1, 4'h0, 4'h0, 4'hF, 1'b0); endtask
  task automatic data_w(); step(1'b1, $urandom, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0); endtask
  task automatic inv_w();  step(1'b1, $urandom, 4'h0, 4'h1, 4'h0, 4'hF, 1'b0); endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  k, e, dp, ss;
    logic        rdy;
    bit          clr;
    int          r;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_flags", {28'd0, out_valid, out_err, out_os, word_sync}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cnt", {los_count, invalid_count}, 32'd0);
    reset_n = 1'b1;

    // Broken OS run must not acquire; the last three OS do.
    os_w(); os_w(); data_w(); os_w(); os_w(); os_w();
    data_w(); data_w();
    chk("sync_after_acq", {31'd0, word_sync}, 32'd1);

    // Four consecutive invalid words drop sync.
    inv_w(); inv_w(); inv_w(); inv_w();
    data_w(); data_w();
    chk("los_after_4inv", {16'd0, los_count}, 32'd1);
    chk("inv_after_4inv", {16'd0, invalid_count}, 32'd4);
    chk("sync_after_4inv", {31'd0, word_sync}, 32'd0);

    // Good run steps depth back by one; four more invalids then lose sync.
    os_w(); os_w(); os_w();
    inv_w(); data_w(); data_w(); inv_w(); inv_w(); inv_w();
    data_w(); data_w(); inv_w(); inv_w();
    data_w(); data_w();
    chk("los_after_goodrun", {16'd0, los_count}, 32'd2);

    // rx_ready dropout for one word, then re-acquire.
    os_w(); os_w(); os_w(); data_w();
    step(1'b0, $urandom, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0);
    data_w(); data_w();
    chk("los_after_ready", {16'd0, los_count}, 32'd3);
    chk("inv_after_ready", {16'd0, invalid_count}, 32'd10);
    os_w(); os_w(); os_w(); data_w(); data_w();
    chk("sync_after_reacq", {31'd0, word_sync}, 32'd1);

    // Saturation: pending words are valid data in sync, so only the register needs seeding.
    force dut.r_invalid_count = 16'hFFFF;
    #1;
    release dut.r_invalid_count;
    m_inv = CMAX;
    foreach (q[i]) q[i].inv = CMAX;
    inv_w(); data_w(); data_w();
    chk("inv_saturated", {16'd0, invalid_count}, 32'h0000FFFF);
    step(1'b1, $urandom, 4'h0, 4'h2, 4'h0, 4'hF, 1'b1);
    data_w(); data_w(); data_w();
    chk("inv_cleared", {16'd0, invalid_count}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      rdy = 1'b1; k = 4'h0; e = 4'h0; dp = 4'h0; ss = 4'hF; clr = 1'b0;
      d = $urandom;
      if (r < 45) begin
        d = IDLE; k = 4'h1;
      end else if (r < 70) begin
        k = 4'h0;
      end else if (r < 90) begin
        case ($urandom_range(0, 4))
          0: e  = 4'(1 << $urandom_range(0, 3));
          1: dp = 4'(1 << $urandom_range(0, 3));
          2: ss = 4'hF & ~4'(1 << $urandom_range(0, 3));
          3: k  = 4'(2 << $urandom_range(0, 2));
          default: begin k = 4'h1; d[7:0] = 8'h3C; end
        endcase
      end else if (r < 96) begin
        rdy = 1'b0;
      end else begin
        clr = 1'b1;
      end
      step(rdy, d, k, e, dp, ss, clr);
    end
    os_w(); os_w(); os_w(); inv_w(); inv_w(); data_w(); data_w();

    // Asynchronous reset mid-operation.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_flags", {28'd0, out_valid, out_err, out_os, word_sync}, 32'd0);
    chk("arst_cnt", {los_count, invalid_count}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    os_w(); os_w(); os_w(); data_w(); data_w();
    chk("sync_after_arst", {31'd0, word_sync}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
